// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register carrying an opaque
// WIDTH-bit payload over a valid/ready handshake. A two-entry skid buffer
// (main + skid) keeps in_ready fully registered, so out_ready never reaches
// in_ready combinationally. Synchronous flush squashes the stage to a bubble.
// Optional build macro PIPE_STAGE_STATS_EN adds saturating stall_cycles and
// xfer_count statistics ports.
module pipe_stage_reg #(
    parameter int WIDTH         = 32,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    // State encoding is literally {main_valid, skid_valid}; ORPHAN (0,1)
    // is never entered legally and only exists so it can be recovered from.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ORPHAN = 2'b01,
        FULL   = 2'b10,
        SKID   = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_nxt;
    logic             main_valid;
    logic             skid_valid;
    logic             in_fire;
    logic             out_fire;

    // A zero-width payload or counter cannot be built; stop elaboration.
    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_reg: WIDTH and CNT_W must be >= 1");
    end

    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign out_data   = main_data;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = main_valid & out_ready;

    // Next-state and payload selection; flush overrides every handshake,
    // and payload registers only change on the fire that qualifies them.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_data;
        skid_nxt  = skid_data;
        if (flush) begin
            state_nxt = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_nxt = '0;
                skid_nxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = in_data;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (out_fire && in_fire) begin
                        main_nxt = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end else if (in_fire) begin
                        skid_nxt  = in_data;
                        state_nxt = SKID;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_nxt  = skid_data;
                        state_nxt = FULL;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers, cleared asynchronously by active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_nxt;
            skid_data <= skid_nxt;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Saturating statistics; flush does not touch them, a transfer in a
    // flush cycle still counts because downstream already took the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            xfer_count   <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (out_fire && xfer_count != '1) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. Two instances
// share all inputs: one clears payload on flush, one holds it. A queue-based
// reference model predicts every output; a vector table and hand sequences
// cover reset, streaming, backpressure, flush and statistics saturation.
module tb_pipe_stage_reg;

    localparam int W   = 16;
    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         in_ready, out_valid, h_in_ready, h_out_valid;
    logic [W-1:0] out_data, h_out_data;
    logic [1:0]   occupancy, h_occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cycles, xfer_count, h_stall_cycles, h_xfer_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] m_head_z;
    logic [W-1:0] m_head_h;
    int           m_stall;
    int           m_xfer;

    typedef struct {
        logic         fl;
        logic         iv;
        logic         ordy;
        logic [W-1:0] d;
        logic         ov;
        logic [W-1:0] od;
        logic         ir;
        logic [1:0]   occ;
    } vec_t;

    vec_t vq[$];

    pipe_stage_reg #(.WIDTH(W), .ZERO_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cycles(stall_cycles), .xfer_count(xfer_count)
`endif
    );

    pipe_stage_reg #(.WIDTH(W), .ZERO_ON_FLUSH(1'b0), .CNT_W(CW)) dut_hold (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .occupancy(h_occupancy)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cycles(h_stall_cycles), .xfer_count(h_xfer_count)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_head_z = '0;
        m_head_h = '0;
        m_stall  = 0;
        m_xfer   = 0;
    endtask

    task automatic addVec(input logic fl, input logic iv, input logic ordy, input logic [W-1:0] d,
                          input logic ov, input logic [W-1:0] od, input logic ir, input logic [1:0] occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge pass, then advance the model.
    task automatic applyStimulus(input logic fl, input logic iv, input logic ordy, input logic [W-1:0] d);
        bit inf, outf, stl;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
        inf  = iv && (mq.size() < 2);
        outf = (mq.size() > 0) && ordy;
        stl  = (mq.size() > 0) && !ordy;
        @(posedge clk);
        #1;
        if (stl && m_stall < MAX) m_stall++;
        if (outf && m_xfer < MAX) m_xfer++;
        if (fl) begin
            mq.delete();
            m_head_z = '0;
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(d);
            if (mq.size() > 0) begin
                m_head_z = mq[0];
                m_head_h = mq[0];
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        compareValue({tag, " out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        compareValue({tag, " out_data"}, 32'(out_data), 32'(m_head_z));
        compareValue({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        compareValue({tag, " occupancy"}, 32'(occupancy), 32'(mq.size()));
        compareValue({tag, " hold out_valid"}, 32'(h_out_valid), 32'(mq.size() > 0));
        compareValue({tag, " hold out_data"}, 32'(h_out_data), 32'(m_head_h));
`ifdef PIPE_STAGE_STATS_EN
        compareValue({tag, " stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        compareValue({tag, " xfer_count"}, 32'(xfer_count), 32'(m_xfer));
`endif
    endtask

    task automatic doReset();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        reset = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Watchdog so the run always ends even if the clock stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        doReset();
        checkOutput("reset");

        // Asynchronous reset mid-stream, observed before any clock edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234);
        compareValue("load 1234", 32'(out_data), 32'h1234);
        checkOutput("load");
        #2;
        reset = 1'b0;
        #1;
        compareValue("async rst out_valid", 32'(out_valid), 32'd0);
        compareValue("async rst out_data", 32'(out_data), 32'd0);
        compareValue("async rst in_ready", 32'(in_ready), 32'd1);
        compareValue("async rst occupancy", 32'(occupancy), 32'd0);
        modelReset();
        #1;
        reset = 1'b1;
        checkOutput("after async reset");

        // Streaming, backpressure and flush vectors.
        addVec(0, 1, 1, 16'h1, 1, 16'h1, 1, 2'd1);
        addVec(0, 1, 1, 16'h2, 1, 16'h2, 1, 2'd1);
        addVec(0, 1, 1, 16'h3, 1, 16'h3, 1, 2'd1);
        addVec(0, 1, 1, 16'h4, 1, 16'h4, 1, 2'd1);
        addVec(0, 0, 1, 16'h0, 0, 16'h4, 1, 2'd0);
        addVec(0, 1, 0, 16'hA, 1, 16'hA, 1, 2'd1);
        addVec(0, 1, 0, 16'hB, 1, 16'hA, 0, 2'd2);
        addVec(0, 1, 0, 16'hC, 1, 16'hA, 0, 2'd2);
        addVec(0, 0, 1, 16'h0, 1, 16'hB, 1, 2'd1);
        addVec(0, 0, 1, 16'h0, 0, 16'hB, 1, 2'd0);
        addVec(0, 1, 0, 16'hA, 1, 16'hA, 1, 2'd1);
        addVec(0, 1, 0, 16'hB, 1, 16'hA, 0, 2'd2);
        addVec(1, 1, 0, 16'hC, 0, 16'h0, 1, 2'd0);
        addVec(0, 0, 0, 16'h0, 0, 16'h0, 1, 2'd0);
        addVec(0, 1, 1, 16'hD, 1, 16'hD, 1, 2'd1);
        addVec(1, 1, 1, 16'hE, 0, 16'h0, 1, 2'd0);
        addVec(0, 0, 0, 16'h0, 0, 16'h0, 1, 2'd0);
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].d);
            compareValue($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].ov));
            compareValue($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vq[i].od));
            compareValue($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vq[i].ir));
            compareValue($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vq[i].occ));
        end

        // Flush with payload hold: only the valid flag drops.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h55);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        compareValue("hold flush out_valid", 32'(h_out_valid), 32'd0);
        compareValue("hold flush out_data", 32'(h_out_data), 32'h55);
        compareValue("zero flush out_data", 32'(out_data), 32'h0);
        checkOutput("flush pair");

        // Statistics saturation and flush immunity.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h7);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
`ifdef PIPE_STAGE_STATS_EN
        compareValue("stall saturated", 32'(stall_cycles), 32'd3);
        compareValue("xfer before", 32'(xfer_count), 32'd0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
`ifdef PIPE_STAGE_STATS_EN
        compareValue("xfer two", 32'(xfer_count), 32'd2);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h9);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
`ifdef PIPE_STAGE_STATS_EN
        compareValue("stall after flush", 32'(stall_cycles), 32'd3);
        compareValue("xfer after flush", 32'(xfer_count), 32'd2);
`endif
        checkOutput("stats seq");

        // Randomised traffic against the queue model.
        doReset();
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(15) == 0, $urandom_range(3) != 0,
                          $urandom_range(1) == 1, W'($urandom));
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
